// File: rtl/axi_llc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_llc_pkg
// Description : Shared types and constants for the LLC way router.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_llc_pkg;

    localparam int unsigned DataMacroLatency   = 1;
    localparam int unsigned DefaultNumWays     = 8;
    localparam int unsigned DefaultNumRspPorts = 2;

    typedef logic [$clog2(DefaultNumWays)-1:0]     way_idx_t;
    typedef logic [$clog2(DefaultNumRspPorts)-1:0] rsp_port_idx_t;

    typedef struct packed {
        logic [DefaultNumWays-1:0] way_ind;
        logic [31:0]               data;
    } way_req_t;

    typedef logic [31:0] way_rsp_t;

endpackage
`default_nettype wire

// File: rtl/axi_llc_rsp_orderer.sv
`default_nettype none
// ============================================================================
// Module      : axi_llc_rsp_orderer
// Description : Per-port ordering FIFO of way indices, head compare source and
//               optional stall counter (AXI_LLC_WAY_ROUTER_PERF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_llc_rsp_orderer #(
    parameter int unsigned Depth   = 9,
    parameter int unsigned WayIdxW = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [WayIdxW-1:0] push_way_i,
    input  logic               pop_i,
    input  logic               match_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [WayIdxW-1:0] head_o
`ifdef AXI_LLC_WAY_ROUTER_PERF_EN
    ,
    output logic [31:0]        perf_stall_o
`endif
);

    localparam int unsigned c_ptr_w = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned c_cnt_w = $clog2(Depth + 1);

    logic [WayIdxW-1:0] r_mem [Depth];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_push;
    logic               w_pop;

    assign full_o  = (r_cnt == c_cnt_w'(Depth));
    assign empty_o = (r_cnt == '0);
    // A full FIFO refuses a push even when it pops the same cycle.
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign head_o  = r_mem[r_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= push_way_i;
                r_wptr <= (r_wptr == c_ptr_w'(Depth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_ptr_w'(Depth - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef AXI_LLC_WAY_ROUTER_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf <= '0;
        end else if (!empty_o && !match_i && (r_perf != '1)) begin
            r_perf <= r_perf + 1'b1;
        end
    end

    assign perf_stall_o = r_perf;
`else
    logic w_unused_match;
    assign w_unused_match = match_i;
`endif

endmodule
`default_nettype wire

// File: rtl/axi_llc_way_router.sv
`default_nettype none
// ============================================================================
// Module      : axi_llc_way_router
// Description : Unit-to-way request crossbar with per-way read credits and
//               in-order read-response routing to response ports.
//               Optional stall counters: AXI_LLC_WAY_ROUTER_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_llc_way_router #(
    parameter int unsigned NumUnits       = 4,
    parameter int unsigned NumWays        = 8,
    parameter int unsigned NumRspPorts    = 2,
    parameter int unsigned PortFifoDepth  = NumWays + axi_llc_pkg::DataMacroLatency,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         way_req_t      = axi_llc_pkg::way_req_t,
    parameter type         way_rsp_t      = axi_llc_pkg::way_rsp_t
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         test_i,
    input  way_req_t [NumUnits-1:0]                      req_i,
    input  logic     [NumUnits-1:0]                      req_read_i,
    input  logic     [NumUnits-1:0][$clog2(NumRspPorts)-1:0] req_port_i,
    input  logic     [NumUnits-1:0]                      req_valid_i,
    output logic     [NumUnits-1:0]                      req_ready_o,
    output way_req_t [NumWays-1:0]                       way_req_o,
    output logic     [NumWays-1:0]                       way_req_valid_o,
    input  logic     [NumWays-1:0]                       way_req_ready_i,
    input  way_rsp_t [NumWays-1:0]                       way_rsp_i,
    input  logic     [NumWays-1:0]                       way_rsp_valid_i,
    output logic     [NumWays-1:0]                       way_rsp_ready_o,
    output way_rsp_t [NumRspPorts-1:0]                   rsp_o,
    output logic     [NumRspPorts-1:0]                   rsp_valid_o,
    input  logic     [NumRspPorts-1:0]                   rsp_ready_i
`ifdef AXI_LLC_WAY_ROUTER_PERF_EN
    ,
    output logic     [NumRspPorts-1:0][31:0]             perf_stall_o
`endif
);
    import axi_llc_pkg::*;

    localparam int unsigned c_way_w  = (NumWays > 1) ? $clog2(NumWays) : 1;
    localparam int unsigned c_port_w = $clog2(NumRspPorts);
    localparam int unsigned c_unit_w = (NumUnits > 1) ? $clog2(NumUnits) : 1;
    localparam int unsigned c_cred_w = $clog2(MaxOutstanding + 1);
    localparam int unsigned c_tptr_w = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [NumUnits-1:0][NumWays-1:0]  w_unit_ind;
    logic [NumUnits-1:0][c_way_w-1:0]  w_unit_way;
    logic [NumUnits-1:0]               w_elig;
    logic [NumUnits-1:0]               w_acc;
    logic [NumRspPorts-1:0]            w_port_claim;
    logic [NumWays-1:0][NumUnits-1:0]  w_req;
    logic [NumWays-1:0]                w_gnt_vld;
    logic [NumWays-1:0][c_unit_w-1:0]  w_gnt_idx;
    logic [NumWays-1:0]                r_locked;
    logic [NumWays-1:0][c_unit_w-1:0]  r_lock_idx;
    logic [NumWays-1:0][c_unit_w-1:0]  r_rr_ptr;

    logic [NumWays-1:0][c_cred_w-1:0]                      r_credit;
    logic [NumWays-1:0][MaxOutstanding-1:0][c_port_w-1:0]  r_tag_mem;
    logic [NumWays-1:0][c_tptr_w-1:0]                      r_tag_wptr;
    logic [NumWays-1:0][c_tptr_w-1:0]                      r_tag_rptr;
    logic [NumWays-1:0][c_port_w-1:0]                      w_tag_head;
    logic [NumWays-1:0][c_port_w-1:0]                      w_tag_port;
    logic [NumWays-1:0]                                    w_tag_push;
    logic [NumWays-1:0]                                    w_tag_pop;
    logic [NumWays-1:0]                                    w_way_match;

    logic [NumRspPorts-1:0]              w_port_full;
    logic [NumRspPorts-1:0]              w_port_empty;
    logic [NumRspPorts-1:0]              w_port_push;
    logic [NumRspPorts-1:0]              w_port_pop;
    logic [NumRspPorts-1:0][c_way_w-1:0] w_port_head;
    logic [NumRspPorts-1:0][c_way_w-1:0] w_port_push_way;

    logic w_unused_test;
    assign w_unused_test = test_i;

    // Decode each unit's one-hot way selector (lowest set bit wins).
    always_comb begin
        for (int u = 0; u < int'(NumUnits); u++) begin
            w_unit_ind[u] = req_i[u].way_ind;
            w_unit_way[u] = '0;
            for (int w = int'(NumWays) - 1; w >= 0; w--) begin
                if (w_unit_ind[u][w]) begin
                    w_unit_way[u] = c_way_w'(w);
                end
            end
        end
    end

    // Read gating plus per-port fixed-priority claim: lowest unit index wins.
    always_comb begin
        w_port_claim = '0;
        w_elig       = '0;
        for (int u = 0; u < int'(NumUnits); u++) begin
            if (req_valid_i[u]) begin
                if (!req_read_i[u]) begin
                    w_elig[u] = 1'b1;
                end else if (!w_port_full[req_port_i[u]] &&
                             !w_port_claim[req_port_i[u]] &&
                             (r_credit[w_unit_way[u]] < c_cred_w'(MaxOutstanding))) begin
                    w_elig[u]                    = 1'b1;
                    w_port_claim[req_port_i[u]] = 1'b1;
                end
            end
        end
    end

    // Per-way round-robin; a pending grant stays locked until handshake.
    always_comb begin
        logic [c_unit_w-1:0] idx;
        idx       = '0;
        w_gnt_vld = '0;
        w_gnt_idx = '0;
        for (int w = 0; w < int'(NumWays); w++) begin
            for (int u = 0; u < int'(NumUnits); u++) begin
                w_req[w][u] = w_elig[u] && (|w_unit_ind[u]) &&
                              (w_unit_way[u] == c_way_w'(w));
            end
            if (r_locked[w] && w_req[w][r_lock_idx[w]]) begin
                w_gnt_vld[w] = 1'b1;
                w_gnt_idx[w] = r_lock_idx[w];
            end else begin
                for (int k = 0; k < int'(NumUnits); k++) begin
                    idx = c_unit_w'((int'(r_rr_ptr[w]) + k) % int'(NumUnits));
                    if (!w_gnt_vld[w] && w_req[w][idx]) begin
                        w_gnt_vld[w] = 1'b1;
                        w_gnt_idx[w] = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int w = 0; w < int'(NumWays); w++) begin
            way_req_valid_o[w] = w_gnt_vld[w];
            way_req_o[w]       = w_gnt_vld[w] ? req_i[w_gnt_idx[w]] : way_req_t'('0);
            if (w_gnt_vld[w] && way_req_ready_i[w]) begin
                req_ready_o[w_gnt_idx[w]] = 1'b1;
            end
        end
    end

    assign w_acc = req_valid_i & req_ready_o;

    always_comb begin
        w_port_push     = '0;
        w_port_push_way = '0;
        w_tag_push      = '0;
        w_tag_port      = '0;
        for (int u = 0; u < int'(NumUnits); u++) begin
            if (w_acc[u] && req_read_i[u]) begin
                w_port_push[req_port_i[u]]     = 1'b1;
                w_port_push_way[req_port_i[u]] = w_unit_way[u];
                w_tag_push[w_unit_way[u]]      = 1'b1;
                w_tag_port[w_unit_way[u]]      = req_port_i[u];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_locked   <= '0;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else begin
            for (int w = 0; w < int'(NumWays); w++) begin
                if (w_gnt_vld[w] && way_req_ready_i[w]) begin
                    r_locked[w] <= 1'b0;
                    r_rr_ptr[w] <= (w_gnt_idx[w] == c_unit_w'(NumUnits - 1)) ?
                                   '0 : w_gnt_idx[w] + 1'b1;
                end else if (w_gnt_vld[w]) begin
                    r_locked[w]   <= 1'b1;
                    r_lock_idx[w] <= w_gnt_idx[w];
                end else begin
                    r_locked[w] <= 1'b0;
                end
            end
        end
    end

    // Tag FIFO per way; its occupancy doubles as the outstanding-read credit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_credit   <= '0;
            r_tag_mem  <= '0;
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
        end else begin
            for (int w = 0; w < int'(NumWays); w++) begin
                if (w_tag_push[w]) begin
                    r_tag_mem[w][r_tag_wptr[w]] <= w_tag_port[w];
                    r_tag_wptr[w] <= (r_tag_wptr[w] == c_tptr_w'(MaxOutstanding - 1)) ?
                                     '0 : r_tag_wptr[w] + 1'b1;
                end
                if (w_tag_pop[w]) begin
                    r_tag_rptr[w] <= (r_tag_rptr[w] == c_tptr_w'(MaxOutstanding - 1)) ?
                                     '0 : r_tag_rptr[w] + 1'b1;
                end
                case ({w_tag_push[w], w_tag_pop[w]})
                    2'b10:   r_credit[w] <= r_credit[w] + 1'b1;
                    2'b01:   r_credit[w] <= r_credit[w] - 1'b1;
                    default: r_credit[w] <= r_credit[w];
                endcase
            end
        end
    end

    // A way response passes only when both its tag head and the port head agree.
    always_comb begin
        rsp_valid_o     = '0;
        rsp_o           = '0;
        way_rsp_ready_o = '0;
        for (int w = 0; w < int'(NumWays); w++) begin
            w_tag_head[w]  = r_tag_mem[w][r_tag_rptr[w]];
            w_way_match[w] = way_rsp_valid_i[w] && (r_credit[w] != '0) &&
                             !w_port_empty[w_tag_head[w]] &&
                             (w_port_head[w_tag_head[w]] == c_way_w'(w));
            if (w_way_match[w]) begin
                rsp_valid_o[w_tag_head[w]] = 1'b1;
                rsp_o[w_tag_head[w]]       = way_rsp_i[w];
                way_rsp_ready_o[w]         = rsp_ready_i[w_tag_head[w]];
            end
        end
    end

    assign w_tag_pop  = way_rsp_ready_o;
    assign w_port_pop = rsp_valid_o & rsp_ready_i;

    for (genvar p = 0; p < int'(NumRspPorts); p++) begin : g_port
        axi_llc_rsp_orderer #(
            .Depth   (PortFifoDepth),
            .WayIdxW (c_way_w)
        ) u_orderer (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .push_i       (w_port_push[p]),
            .push_way_i   (w_port_push_way[p]),
            .pop_i        (w_port_pop[p]),
            .match_i      (rsp_valid_o[p]),
            .full_o       (w_port_full[p]),
            .empty_o      (w_port_empty[p]),
            .head_o       (w_port_head[p])
`ifdef AXI_LLC_WAY_ROUTER_PERF_EN
            ,
            .perf_stall_o (perf_stall_o[p])
`endif
        );
    end

    for (genvar u = 0; u < int'(NumUnits); u++) begin : g_chk_unit
        a_way_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
            req_valid_i[u] |-> $onehot(w_unit_ind[u]));
        a_port_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (req_valid_i[u] && req_read_i[u]) |->
            ({1'b0, req_port_i[u]} < (c_port_w + 1)'(NumRspPorts)));
    end

    for (genvar w = 0; w < int'(NumWays); w++) begin : g_chk_way
        a_credit_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(w_tag_push[w] && !w_tag_pop[w] && (r_credit[w] == c_cred_w'(MaxOutstanding))));
        a_credit_unf: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(w_tag_pop[w] && (r_credit[w] == '0)));
        a_orphan_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
            way_rsp_valid_i[w] |-> (r_credit[w] != '0));
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_way_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_llc_way_router
// Description : Directed self-checking bench for axi_llc_way_router.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_llc_way_router;
    import axi_llc_pkg::*;

    localparam int NU = 4;
    localparam int NW = 8;
    localparam int NP = 2;

    logic                     clk_i  = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     test_i = 1'b0;
    way_req_t [NU-1:0]        req_i;
    logic     [NU-1:0]        req_read_i;
    logic     [NU-1:0][0:0]   req_port_i;
    logic     [NU-1:0]        req_valid_i;
    logic     [NU-1:0]        req_ready_o;
    way_req_t [NW-1:0]        way_req_o;
    logic     [NW-1:0]        way_req_valid_o;
    logic     [NW-1:0]        way_req_ready_i;
    way_rsp_t [NW-1:0]        way_rsp_i;
    logic     [NW-1:0]        way_rsp_valid_i;
    logic     [NW-1:0]        way_rsp_ready_o;
    way_rsp_t [NP-1:0]        rsp_o;
    logic     [NP-1:0]        rsp_valid_o;
    logic     [NP-1:0]        rsp_ready_i;
`ifdef AXI_LLC_WAY_ROUTER_PERF_EN
    logic     [NP-1:0][31:0]  perf_stall_o;
`endif

    int checks = 0;
    int errors = 0;

    axi_llc_way_router dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .test_i          (test_i),
        .req_i           (req_i),
        .req_read_i      (req_read_i),
        .req_port_i      (req_port_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .way_req_o       (way_req_o),
        .way_req_valid_o (way_req_valid_o),
        .way_req_ready_i (way_req_ready_i),
        .way_rsp_i       (way_rsp_i),
        .way_rsp_valid_i (way_rsp_valid_i),
        .way_rsp_ready_o (way_rsp_ready_o),
        .rsp_o           (rsp_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i)
`ifdef AXI_LLC_WAY_ROUTER_PERF_EN
        ,
        .perf_stall_o    (perf_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic way_req_t mk(input int way, input logic [31:0] d);
        way_req_t r;
        r.way_ind      = '0;
        r.way_ind[way] = 1'b1;
        r.data         = d;
        return r;
    endfunction

    task automatic clear_inputs();
        req_i           = '0;
        req_read_i      = '0;
        req_port_i      = '0;
        req_valid_i     = '0;
        way_req_ready_i = '1;
        way_rsp_i       = '0;
        way_rsp_valid_i = '0;
        rsp_ready_i     = '1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Holds a request until accepted (bounded), then drops it.
    task automatic issue(input int u, input int way, input bit rd, input int port,
                         input logic [31:0] d);
        int n;
        n              = 0;
        req_i[u]       = mk(way, d);
        req_read_i[u]  = rd;
        req_port_i[u]  = 1'(port);
        req_valid_i[u] = 1'b1;
        #1;
        while (!req_ready_o[u] && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready_o[u] !== 1'b1) begin
            errors++;
            $display("FAIL issue_timeout unit=%0d way=%0d ready=%b required 1", u, way, req_ready_o[u]);
        end
        tick();
        req_valid_i[u] = 1'b0;
        req_read_i[u]  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_req_ready got=%b required 0", req_ready_o); end
        checks++;
        if (way_req_valid_o !== 8'b0) begin errors++; $display("FAIL reset_way_valid got=%b required 0", way_req_valid_o); end
        checks++;
        if (way_req_o !== '0) begin errors++; $display("FAIL reset_way_payload got=%h required 0", way_req_o); end
        checks++;
        if (rsp_valid_o !== 2'b0 || rsp_o !== '0) begin errors++; $display("FAIL reset_rsp got=%b/%h required 0", rsp_valid_o, rsp_o); end
        checks++;
        if (way_rsp_ready_o !== 8'b0) begin errors++; $display("FAIL reset_way_rsp_ready got=%b required 0", way_rsp_ready_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        req_i[0] = mk(3, 32'hA0); req_read_i[0] = 1'b1; req_port_i[0] = 1'b1; req_valid_i[0] = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL single_req_ready got=%b required 0001", req_ready_o); end
        checks++;
        if (way_req_valid_o !== 8'b0000_1000) begin errors++; $display("FAIL single_way_valid got=%b required 00001000", way_req_valid_o); end
        checks++;
        if (way_req_o[3].data !== 32'hA0) begin errors++; $display("FAIL single_way_data got=%h required a0", way_req_o[3].data); end
        tick();
        req_valid_i[0] = 1'b0; req_read_i[0] = 1'b0;
        checks++;
        if (dut.r_credit[3] !== 3'd1) begin errors++; $display("FAIL single_credit_inc got=%0d required 1", dut.r_credit[3]); end
        tick();
        way_rsp_i[3] = 32'hD3; way_rsp_valid_i[3] = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o !== 2'b10 || rsp_o[1] !== 32'hD3) begin errors++; $display("FAIL single_rsp got=%b/%h required 10/d3", rsp_valid_o, rsp_o[1]); end
        checks++;
        if (way_rsp_ready_o !== 8'h08) begin errors++; $display("FAIL single_way_rsp_ready got=%b required 00001000", way_rsp_ready_o); end
        tick();
        way_rsp_valid_i[3] = 1'b0;
        #1;
        checks++;
        if (dut.r_credit[3] !== 3'd0 || rsp_valid_o !== 2'b00) begin errors++; $display("FAIL single_credit_ret got=%0d/%b required 0/00", dut.r_credit[3], rsp_valid_o); end
    endtask

    task automatic test_reorder();
        issue(0, 5, 1'b1, 0, 32'h5);
        issue(0, 2, 1'b1, 0, 32'h2);
        way_rsp_i[2] = 32'h22; way_rsp_valid_i[2] = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o[0] !== 1'b0 || way_rsp_ready_o[2] !== 1'b0) begin errors++; $display("FAIL reorder_hold got=%b/%b required 0/0", rsp_valid_o[0], way_rsp_ready_o[2]); end
        tick();
        way_rsp_i[5] = 32'h55; way_rsp_valid_i[5] = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o[0] !== 1'b1 || rsp_o[0] !== 32'h55 || way_rsp_ready_o !== 8'h20) begin
            errors++; $display("FAIL reorder_first got=%b/%h/%b required 1/55/00100000", rsp_valid_o[0], rsp_o[0], way_rsp_ready_o);
        end
        tick();
        way_rsp_valid_i[5] = 1'b0;
        #1;
        checks++;
        if (rsp_valid_o[0] !== 1'b1 || rsp_o[0] !== 32'h22 || way_rsp_ready_o !== 8'h04) begin
            errors++; $display("FAIL reorder_second got=%b/%h/%b required 1/22/00000100", rsp_valid_o[0], rsp_o[0], way_rsp_ready_o);
        end
        tick();
        way_rsp_valid_i[2] = 1'b0;
    endtask

    task automatic test_credit_limit();
        for (int i = 0; i < 4; i++) issue(0, 1, 1'b1, 0, 32'h10 + i);
        req_i[0] = mk(1, 32'h14); req_read_i[0] = 1'b1; req_port_i[0] = 1'b0; req_valid_i[0] = 1'b1;
        #1;
        checks++;
        if (req_ready_o[0] !== 1'b0 || way_req_valid_o[1] !== 1'b0) begin errors++; $display("FAIL credit_stall got=%b/%b required 0/0", req_ready_o[0], way_req_valid_o[1]); end
        tick();
        checks++;
        if (req_ready_o[0] !== 1'b0) begin errors++; $display("FAIL credit_stall_hold got=%b required 0", req_ready_o[0]); end
        way_rsp_i[1] = 32'h91; way_rsp_valid_i[1] = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o[0] !== 1'b1 || req_ready_o[0] !== 1'b0) begin errors++; $display("FAIL credit_pop_cycle got=%b/%b required 1/0", rsp_valid_o[0], req_ready_o[0]); end
        tick();
        way_rsp_valid_i[1] = 1'b0;
        #1;
        checks++;
        if (req_ready_o[0] !== 1'b1) begin errors++; $display("FAIL credit_release got=%b required 1", req_ready_o[0]); end
        tick();
        req_valid_i[0] = 1'b0; req_read_i[0] = 1'b0;
        way_rsp_valid_i[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            way_rsp_i[1] = 32'h92 + i;
            #1;
            checks++;
            if (rsp_valid_o[0] !== 1'b1 || rsp_o[0] !== 32'h92 + i) begin errors++; $display("FAIL credit_drain%0d got=%b/%h required 1/%h", i, rsp_valid_o[0], rsp_o[0], 32'h92 + i); end
            tick();
        end
        way_rsp_valid_i[1] = 1'b0;
        #1;
        checks++;
        if (dut.r_credit[1] !== 3'd0) begin errors++; $display("FAIL credit_empty got=%0d required 0", dut.r_credit[1]); end
    endtask

    task automatic test_port_full();
        int seq [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 3};
        for (int i = 0; i < 9; i++) issue(0, i % 8, 1'b1, 0, 32'h300 + i);
        req_i[0] = mk(3, 32'h3FF); req_read_i[0] = 1'b1; req_port_i[0] = 1'b0; req_valid_i[0] = 1'b1;
        req_i[2] = mk(4, 32'h444); req_read_i[2] = 1'b0; req_valid_i[2] = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL full_ready got=%b required 0100", req_ready_o); end
        checks++;
        if (way_req_valid_o !== 8'b0001_0000 || way_req_o[4].data !== 32'h444) begin errors++; $display("FAIL full_write_pass got=%b/%h required 00010000/444", way_req_valid_o, way_req_o[4].data); end
        tick();
        req_valid_i[2] = 1'b0;
        #1;
        checks++;
        if (req_ready_o[0] !== 1'b0) begin errors++; $display("FAIL full_hold got=%b required 0", req_ready_o[0]); end
        way_rsp_i[0] = 32'hE0; way_rsp_valid_i[0] = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o[0] !== 1'b1 || rsp_o[0] !== 32'hE0) begin errors++; $display("FAIL full_pop got=%b/%h required 1/e0", rsp_valid_o[0], rsp_o[0]); end
        tick();
        way_rsp_valid_i[0] = 1'b0;
        #1;
        checks++;
        if (req_ready_o[0] !== 1'b1) begin errors++; $display("FAIL full_release got=%b required 1", req_ready_o[0]); end
        tick();
        req_valid_i[0] = 1'b0; req_read_i[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            way_rsp_i[seq[i]] = 32'hF00 + i; way_rsp_valid_i[seq[i]] = 1'b1;
            #1;
            checks++;
            if (rsp_valid_o[0] !== 1'b1 || rsp_o[0] !== 32'hF00 + i) begin errors++; $display("FAIL full_drain%0d got=%b/%h required 1/%h", i, rsp_valid_o[0], rsp_o[0], 32'hF00 + i); end
            tick();
            way_rsp_valid_i[seq[i]] = 1'b0;
        end
    endtask

    task automatic test_same_cycle_conflict();
        req_i[1] = mk(6, 32'h6); req_read_i[1] = 1'b1; req_port_i[1] = 1'b1; req_valid_i[1] = 1'b1;
        req_i[3] = mk(7, 32'h7); req_read_i[3] = 1'b1; req_port_i[3] = 1'b1; req_valid_i[3] = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL conflict_first got=%b required 0010", req_ready_o); end
        tick();
        req_valid_i[1] = 1'b0; req_read_i[1] = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL conflict_second got=%b required 1000", req_ready_o); end
        tick();
        req_valid_i[3] = 1'b0; req_read_i[3] = 1'b0;
        way_rsp_i[6] = 32'h66; way_rsp_i[7] = 32'h77; way_rsp_valid_i[7:6] = 2'b11;
        #1;
        checks++;
        if (rsp_o[1] !== 32'h66 || way_rsp_ready_o !== 8'h40) begin errors++; $display("FAIL conflict_rsp1 got=%h/%b required 66/01000000", rsp_o[1], way_rsp_ready_o); end
        tick();
        way_rsp_valid_i[6] = 1'b0;
        #1;
        checks++;
        if (rsp_o[1] !== 32'h77 || way_rsp_ready_o !== 8'h80) begin errors++; $display("FAIL conflict_rsp2 got=%h/%b required 77/10000000", rsp_o[1], way_rsp_ready_o); end
        tick();
        way_rsp_valid_i[7] = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue(0, 1, 1'b1, 0, 32'h1);
        issue(0, 2, 1'b1, 1, 32'h2);
        issue(0, 3, 1'b1, 0, 32'h3);
        rst_ni = 1'b0;
        way_rsp_i[1] = 32'hBAD; way_rsp_valid_i[1] = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o !== 2'b00 || way_rsp_ready_o !== 8'h00 || way_req_valid_o !== 8'h00) begin
            errors++; $display("FAIL rstmid_valids got=%b/%b/%b required 0/0/0", rsp_valid_o, way_rsp_ready_o, way_req_valid_o);
        end
        checks++;
        if (dut.g_port[0].u_orderer.empty_o !== 1'b1 || dut.g_port[1].u_orderer.empty_o !== 1'b1 || dut.r_credit[1] !== 3'd0) begin
            errors++; $display("FAIL rstmid_empty got=%b/%b/%0d required 1/1/0", dut.g_port[0].u_orderer.empty_o, dut.g_port[1].u_orderer.empty_o, dut.r_credit[1]);
        end
        tick();
        way_rsp_valid_i[1] = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        issue(3, 2, 1'b1, 1, 32'h2B);
        way_rsp_i[2] = 32'hBEEF; way_rsp_valid_i[2] = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o !== 2'b10 || rsp_o[1] !== 32'hBEEF) begin errors++; $display("FAIL rstmid_fresh got=%b/%h required 10/beef", rsp_valid_o, rsp_o[1]); end
        tick();
        way_rsp_valid_i[2] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_reorder();
        test_credit_limit();
        test_port_full();
        test_same_cycle_conflict();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
